// File: rtl/watch_mode_cu_pkg.sv
// -----------------------------------------------------------------------------
// watch_defs : shared definitions for the stopwatch/clock mode controller and
// the future alarm-set logic.
//   state_t     : 3-bit controller state encoding
//   FIELD_*     : bit index of each time field inside the one-hot o_inc/o_blank
//   btn_t       : decoded winning button; pick_btn() applies the priority
//                 set > mode > clear > run
//   out_t       : bundle of all registered controller outputs
// -----------------------------------------------------------------------------
package watch_defs;

  typedef enum logic [2:0] {
    ST_STOPWATCH = 3'd0,
    ST_CLOCK     = 3'd1,
    ST_SET_HOUR  = 3'd2,
    ST_SET_MIN   = 3'd3,
    ST_SET_SEC   = 3'd4
  } state_t;

  localparam int FIELD_HOUR = 2;
  localparam int FIELD_MIN  = 1;
  localparam int FIELD_SEC  = 0;

  // Listed in priority order, highest first after BTN_NONE.
  typedef enum logic [2:0] {
    BTN_NONE  = 3'd0,
    BTN_SET   = 3'd1,
    BTN_MODE  = 3'd2,
    BTN_CLEAR = 3'd3,
    BTN_RUN   = 3'd4
  } btn_t;

  typedef struct packed {
    logic       disp_sel;
    logic       set_active;
    logic       sw_run;
    logic       sw_clear;
    logic [2:0] inc;
    logic [2:0] blank;
  } out_t;

  localparam out_t OUT_RESET = '{disp_sel: 1'b1, set_active: 1'b0, sw_run: 1'b0,
                                 sw_clear: 1'b0, inc: 3'b000, blank: 3'b000};

  // Only the highest-priority asserted pulse survives; the rest are dropped.
  function automatic btn_t pick_btn(input logic set, input logic mode,
                                    input logic clear, input logic run);
    if (set)        return BTN_SET;
    else if (mode)  return BTN_MODE;
    else if (clear) return BTN_CLEAR;
    else if (run)   return BTN_RUN;
    else            return BTN_NONE;
  endfunction

  function automatic logic is_set_state(input state_t s);
    return (s == ST_SET_HOUR) || (s == ST_SET_MIN) || (s == ST_SET_SEC);
  endfunction

  function automatic logic [2:0] field_onehot(input state_t s);
    logic [2:0] oh;
    oh = 3'b000;
    case (s)
      ST_SET_HOUR: oh[FIELD_HOUR] = 1'b1;
      ST_SET_MIN:  oh[FIELD_MIN]  = 1'b1;
      ST_SET_SEC:  oh[FIELD_SEC]  = 1'b1;
      default:     oh = 3'b000;
    endcase
    return oh;
  endfunction

  // HOUR -> MIN -> SEC -> HOUR
  function automatic state_t next_field(input state_t s);
    case (s)
      ST_SET_HOUR: return ST_SET_MIN;
      ST_SET_MIN:  return ST_SET_SEC;
      default:     return ST_SET_HOUR;
    endcase
  endfunction

endpackage

// File: rtl/watch_mode_cu_if.sv
// -----------------------------------------------------------------------------
// watch_mode_cu_if : button/output bundle of the mode controller.
//   i_btn_mode/set/run/clear : debounced one-cycle button pulses
//   o_sw_btn_run/clear       : pulses forwarded to the stopwatch control unit
//   o_disp_sel               : 0 = stopwatch owns the display, 1 = clock
//   o_set_active             : high in any set state
//   o_inc[2:0]               : one-hot increment pulse {hour, min, sec}
//   o_blank[2:0]             : one-hot field blanked this cycle
// master drives the buttons (board/bench), slave is the controller.
// -----------------------------------------------------------------------------
interface watch_mode_cu_if;
  logic       i_btn_mode;
  logic       i_btn_set;
  logic       i_btn_run;
  logic       i_btn_clear;
  logic       o_sw_btn_run;
  logic       o_sw_btn_clear;
  logic       o_disp_sel;
  logic       o_set_active;
  logic [2:0] o_inc;
  logic [2:0] o_blank;

  modport master (
    output i_btn_mode, i_btn_set, i_btn_run, i_btn_clear,
    input  o_sw_btn_run, o_sw_btn_clear, o_disp_sel, o_set_active, o_inc, o_blank
  );

  modport slave (
    input  i_btn_mode, i_btn_set, i_btn_run, i_btn_clear,
    output o_sw_btn_run, o_sw_btn_clear, o_disp_sel, o_set_active, o_inc, o_blank
  );
endinterface

// File: rtl/watch_blink_timer.sv
// -----------------------------------------------------------------------------
// watch_blink_timer : blink phase generator plus idle-timeout detector for the
// time-set procedures (clock set today, alarm set later).
//   clk, rst      : clock, synchronous active-high reset
//   i_enable      : set procedure will be active next cycle; low clears all
//   i_restart     : restart both counters (entry, field change, increment)
//   o_phase_next  : blink phase the register takes at this edge
//                   (0 = field visible, 1 = blanked)
//   o_timeout     : idle count has reached TIMEOUT_CYC-1
// Optional feature macro: WATCH_SET_TIMEOUT_EN (timeout counter present only
// when defined; otherwise o_timeout is tied low).
// -----------------------------------------------------------------------------
module watch_blink_timer #(
  parameter int unsigned BLINK_HALF  = 50_000_000,
  parameter int unsigned TIMEOUT_CYC = 1_000_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_enable,
  input  logic i_restart,
  output logic o_phase_next,
  output logic o_timeout
);

  localparam int unsigned BLINK_W = $clog2(BLINK_HALF);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;

  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (!i_enable || i_restart) begin
      // Restart lands in the visible half so the edited field shows at once.
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign o_phase_next = phase_d;

`ifdef WATCH_SET_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt_q;

  // Saturates at TO_LAST so a stalled exit can never wrap back to zero.
  always_ff @(posedge clk) begin
    if (rst || !i_enable || i_restart) begin
      to_cnt_q <= '0;
    end else if (to_cnt_q != TO_LAST) begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  // Decoded from the register only, so it cannot loop back through i_enable.
  assign o_timeout = (to_cnt_q == TO_LAST);
`else
  localparam bit unused_timeout_cyc = (TIMEOUT_CYC != 0);
  assign o_timeout = 1'b0;
`endif

endmodule

// File: rtl/watch_mode_cu.sv
// -----------------------------------------------------------------------------
// watch_mode_cu : top-level mode controller of the stopwatch/clock board.
// Chooses which datapath owns the display and receives run/clear, and
// sequences the clock time-set procedure (field select, increment, blink,
// optional idle auto-exit).
//   clk, rst : clock, synchronous active-high reset
//   bus      : watch_mode_cu_if.slave (buttons in, control outputs out)
// Parameters: BLINK_HALF (cycles per blink half-period, >= 2),
//             TIMEOUT_CYC (idle cycles before set auto-exit, >= 2).
// Optional feature macro: WATCH_SET_TIMEOUT_EN enables the idle auto-exit.
// All outputs are registered: each reacts one cycle after the button edge.
// -----------------------------------------------------------------------------
module watch_mode_cu
  import watch_defs::*;
#(
  parameter int unsigned BLINK_HALF  = 50_000_000,
  parameter int unsigned TIMEOUT_CYC = 1_000_000_000
) (
  input  logic            clk,
  input  logic            rst,
  watch_mode_cu_if.slave  bus
);

  state_t state_q, state_d;
  btn_t   btn;
  out_t   outs_q, outs_d;
  logic   restart;
  logic   tmr_enable;
  logic   phase_next;
  logic   timeout;

  assign btn = pick_btn(bus.i_btn_set, bus.i_btn_mode, bus.i_btn_clear, bus.i_btn_run);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLOCK;
      outs_q  <= OUT_RESET;
    end else begin
      state_q <= state_d;
      outs_q  <= outs_d;
    end
  end

  // Next-state logic. restart marks every accepted set-procedure event.
  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    case (state_q)
      ST_STOPWATCH: begin
        if (btn == BTN_MODE) state_d = ST_CLOCK;
      end
      ST_CLOCK: begin
        if (btn == BTN_MODE) begin
          state_d = ST_STOPWATCH;
        end else if (btn == BTN_SET) begin
          state_d = ST_SET_HOUR;
          restart = 1'b1;
        end
      end
      ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC: begin
        case (btn)
          BTN_SET:   state_d = ST_CLOCK;
          BTN_CLEAR: begin
            state_d = next_field(state_q);
            restart = 1'b1;
          end
          BTN_RUN:   restart = 1'b1;
          // An ignored mode press does not hold off the auto-exit.
          default:   if (timeout) state_d = ST_CLOCK;
        endcase
      end
      default: state_d = ST_CLOCK;
    endcase
  end

  // Output logic: values the output registers take at this edge.
  always_comb begin
    outs_d            = '0;
    outs_d.disp_sel   = (state_d != ST_STOPWATCH);
    outs_d.set_active = is_set_state(state_d);
    if (state_q == ST_STOPWATCH) begin
      outs_d.sw_run   = (btn == BTN_RUN);
      outs_d.sw_clear = (btn == BTN_CLEAR);
    end
    if (is_set_state(state_q) && (btn == BTN_RUN)) begin
      outs_d.inc = field_onehot(state_q);
    end
    if (is_set_state(state_d) && phase_next) begin
      outs_d.blank = field_onehot(state_d);
    end
  end

  assign tmr_enable = is_set_state(state_d);

  watch_blink_timer #(
    .BLINK_HALF  (BLINK_HALF),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_blink_timer (
    .clk          (clk),
    .rst          (rst),
    .i_enable     (tmr_enable),
    .i_restart    (restart),
    .o_phase_next (phase_next),
    .o_timeout    (timeout)
  );

  assign bus.o_disp_sel     = outs_q.disp_sel;
  assign bus.o_set_active   = outs_q.set_active;
  assign bus.o_sw_btn_run   = outs_q.sw_run;
  assign bus.o_sw_btn_clear = outs_q.sw_clear;
  assign bus.o_inc          = outs_q.inc;
  assign bus.o_blank        = outs_q.blank;

endmodule
